// File: rtl/celem_mon_pkg.sv
// Shared FSM state encoding and violation codes for the C-element protocol monitor.
package celem_mon_pkg;

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        ST_ARM_R = 2'd1,
        ST_HIGH  = 2'd2,
        ST_ARM_F = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_EARLY   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_RETRACT = 2'd3;

    function automatic logic is_armed(input state_t s);
        return (s == ST_ARM_R) || (s == ST_ARM_F);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing one asynchronous pin into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/celem_monitor.sv
// Watches a C-element's inputs and output, counts legal output transitions and
// latches the first protocol violation (early switch, timeout, input retraction).
module celem_monitor
    import celem_mon_pkg::*;
#(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0,
    input  logic             in1,
    input  logic             out,
    input  logic             check_en,
    input  logic             clr,
    output logic             pending,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] toggle_count
);

    localparam int                WAIT_W   = $clog2(TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [2:0] pins;
    logic [2:0] synced;
    logic       s0, s1, so;

    assign pins = {out, in1, in0};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            sync2 u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (pins[gi]),
                .q     (synced[gi])
            );
        end
    endgenerate

    assign s0 = synced[0];
    assign s1 = synced[1];
    assign so = synced[2];

    state_t             state_reg, state_next;
    logic [WAIT_W-1:0]  wait_reg;
    logic [2:0]         prime_reg;
    logic               err_reg;
    logic [1:0]         code_reg;
    logic [CNT_W-1:0]   count_reg;

    logic       both_hi, both_lo, first_sample;
    logic       viol, count_inc, stay_armed;
    logic [1:0] viol_code;

    assign both_hi      = s0 & s1;
    assign both_lo      = ~s0 & ~s1;
    // The synchronizers are primed after two edges; the very first real sample
    // may find out already high, which is an initial condition, not a transition.
    assign first_sample = prime_reg[1] & ~prime_reg[2];

    always_comb begin
        state_next = state_reg;
        viol       = 1'b0;
        viol_code  = ERR_NONE;
        count_inc  = 1'b0;
        stay_armed = 1'b0;
        case (state_reg)
            ST_LOW: begin
                if (so) begin
                    state_next = ST_HIGH;
                    if (first_sample) begin
                        count_inc = 1'b0;
                    end else if (both_hi) begin
                        count_inc = 1'b1;
                    end else begin
                        viol      = 1'b1;
                        viol_code = ERR_EARLY;
                    end
                end else if (both_hi) begin
                    state_next = ST_ARM_R;
                end
            end
            ST_ARM_R: begin
                if (so) begin
                    state_next = ST_HIGH;
                    count_inc  = 1'b1;
                end else if (!both_hi) begin
                    state_next = ST_LOW;
                    viol       = 1'b1;
                    viol_code  = ERR_RETRACT;
                end else begin
                    stay_armed = 1'b1;
                    if (wait_reg == WAIT_LIM) begin
                        viol      = 1'b1;
                        viol_code = ERR_TIMEOUT;
                    end
                end
            end
            ST_HIGH: begin
                if (!so) begin
                    state_next = ST_LOW;
                    if (both_lo) begin
                        count_inc = 1'b1;
                    end else begin
                        viol      = 1'b1;
                        viol_code = ERR_EARLY;
                    end
                end else if (both_lo) begin
                    state_next = ST_ARM_F;
                end
            end
            ST_ARM_F: begin
                if (!so) begin
                    state_next = ST_LOW;
                    count_inc  = 1'b1;
                end else if (!both_lo) begin
                    state_next = ST_HIGH;
                    viol       = 1'b1;
                    viol_code  = ERR_RETRACT;
                end else begin
                    stay_armed = 1'b1;
                    if (wait_reg == WAIT_LIM) begin
                        viol      = 1'b1;
                        viol_code = ERR_TIMEOUT;
                    end
                end
            end
            default: state_next = ST_LOW;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_LOW;
            prime_reg <= 3'b000;
        end else begin
            state_reg <= state_next;
            prime_reg <= {prime_reg[1:0], 1'b1};
        end
    end

    // Counting past TIMEOUT by one and saturating makes the timeout fire once per arming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_reg <= '0;
        end else if (!check_en || !stay_armed) begin
            wait_reg <= '0;
        end else if (wait_reg != WAIT_SAT) begin
            wait_reg <= wait_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg   <= 1'b0;
            code_reg  <= ERR_NONE;
            count_reg <= '0;
        end else if (clr) begin
            err_reg   <= 1'b0;
            code_reg  <= ERR_NONE;
            count_reg <= '0;
        end else begin
            if (viol && check_en && !err_reg) begin
                err_reg  <= 1'b1;
                code_reg <= viol_code;
            end
            if (count_inc && (count_reg != CNT_MAX)) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign pending      = is_armed(state_reg);
    assign error        = err_reg;
    assign err_code     = code_reg;
    assign toggle_count = count_reg;

endmodule

// File: tb/tb_celem_monitor.sv
// Directed bench for celem_monitor: a default instance plus a CNT_W=2 instance
// sharing the same pins to observe counter saturation.
module tb_celem_monitor;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in0      = 1'b0;
    logic        in1      = 1'b0;
    logic        out      = 1'b0;
    logic        check_en = 1'b1;
    logic        clr      = 1'b0;

    logic        pending, error;
    logic [1:0]  err_code;
    logic [15:0] toggle_count;
    logic        pending_s, error_s;
    logic [1:0]  err_code_s;
    logic [1:0]  toggle_count_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    celem_monitor #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in0          (in0),
        .in1          (in1),
        .out          (out),
        .check_en     (check_en),
        .clr          (clr),
        .pending      (pending),
        .error        (error),
        .err_code     (err_code),
        .toggle_count (toggle_count)
    );

    celem_monitor #(.TIMEOUT(8), .CNT_W(2)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .in0          (in0),
        .in1          (in1),
        .out          (out),
        .check_en     (check_en),
        .clr          (clr),
        .pending      (pending_s),
        .error        (error_s),
        .err_code     (err_code_s),
        .toggle_count (toggle_count_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    initial begin
        step(2);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_code", 32'(err_code), 0);
        chk("rst_count", 32'(toggle_count), 0);
        chk("rst_count_sat", 32'(toggle_count_s), 0);
        rst_n = 1'b1;
        step(5);

        // Ideal C-element: inputs shifted by 5, out lags the second input by 2.
        for (int t = 0; t < 50; t++) begin
            in0 = (t % 20) >= 10;
            in1 = (t >= 5) && (((t - 5) % 20) >= 10);
            out = ((t >= 17) && (t < 27)) || ((t >= 37) && (t < 47));
            step(1);
        end
        step(4);
        chk("phase_count", 32'(toggle_count), 4);
        chk("phase_error", 32'(error), 0);
        chk("phase_pending", 32'(pending), 0);
        chk("phase_count_sat", 32'(toggle_count_s), 3);

        in0 = 1'b1; in1 = 1'b1; step(3);
        out = 1'b1; step(5);
        chk("fifth_count", 32'(toggle_count), 5);
        chk("fifth_count_sat", 32'(toggle_count_s), 3);
        chk("fifth_error", 32'(error), 0);
        in0 = 1'b0; in1 = 1'b0; step(3);
        out = 1'b0; step(5);
        chk("sixth_count", 32'(toggle_count), 6);

        // Reset while armed; out high at release must not count or error.
        in0 = 1'b1; in1 = 1'b1; step(4);
        chk("armr_pending", 32'(pending), 1);
        rst_n = 1'b0; out = 1'b1; step(1);
        chk("midrst_pending", 32'(pending), 0);
        chk("midrst_error", 32'(error), 0);
        chk("midrst_code", 32'(err_code), 0);
        chk("midrst_count", 32'(toggle_count), 0);
        chk("midrst_count_sat", 32'(toggle_count_s), 0);
        rst_n = 1'b1; step(6);
        chk("rel_error", 32'(error), 0);
        chk("rel_count", 32'(toggle_count), 0);
        chk("rel_pending", 32'(pending), 0);
        in0 = 1'b0; in1 = 1'b0; step(4);
        chk("armf_pending", 32'(pending), 1);
        out = 1'b0; step(4);
        chk("armf_done_pending", 32'(pending), 0);
        chk("armf_done_count", 32'(toggle_count), 1);
        chk("armf_done_error", 32'(error), 0);

        // Early rise.
        in0 = 1'b1; out = 1'b1; step(4);
        chk("early_error", 32'(error), 1);
        chk("early_code", 32'(err_code), 1);
        chk("early_count", 32'(toggle_count), 1);
        chk("early_pending", 32'(pending), 0);
        in0 = 1'b0; out = 1'b0; step(4);
        chk("early_fall_count", 32'(toggle_count), 2);
        pulse_clr();
        chk("clr_error", 32'(error), 0);
        chk("clr_code", 32'(err_code), 0);
        chk("clr_count", 32'(toggle_count), 0);

        // Timeout: out held low 12 cycles after arming.
        in0 = 1'b1; in1 = 1'b1; step(3);
        chk("to_arm_pending", 32'(pending), 1);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk($sformatf("to_pending_%0d", k), 32'(pending), 1);
            chk($sformatf("to_error_%0d", k), 32'(error), (k >= 9) ? 1 : 0);
        end
        chk("to_code", 32'(err_code), 2);
        in1 = 1'b0; step(4);
        chk("to_retract_pending", 32'(pending), 0);
        chk("to_first_kept", 32'(err_code), 2);
        in0 = 1'b0; step(4);
        pulse_clr();

        // Retraction after 3 cycles armed.
        in0 = 1'b1; in1 = 1'b1; step(3);
        chk("ret_arm_pending", 32'(pending), 1);
        step(3);
        in1 = 1'b0; step(2);
        chk("ret_lat_pending", 32'(pending), 1);
        chk("ret_lat_error", 32'(error), 0);
        step(1);
        chk("ret_pending", 32'(pending), 0);
        chk("ret_error", 32'(error), 1);
        chk("ret_code", 32'(err_code), 3);
        in0 = 1'b0; step(3);
        pulse_clr();
        chk("ret_clr_error", 32'(error), 0);

        // Violation coincident with clr is dropped; the following ARM_F times out.
        out = 1'b1; step(2);
        clr = 1'b1; step(1);
        clr = 1'b0;
        chk("clrwin_error", 32'(error), 0);
        step(2);
        chk("clrwin_error_late", 32'(error), 0);
        chk("clrwin_pending", 32'(pending), 1);
        step(12);
        chk("clrwin_to_error", 32'(error), 1);
        chk("clrwin_to_code", 32'(err_code), 2);
        out = 1'b0; step(4);
        chk("clrwin_fall_pending", 32'(pending), 0);
        pulse_clr();
        chk("clrwin_clr_count", 32'(toggle_count), 0);

        // Checking disabled: tracking continues, nothing recorded.
        check_en = 1'b0;
        out = 1'b1; step(4);
        chk("nochk_error", 32'(error), 0);
        chk("nochk_pending", 32'(pending), 1);
        step(12);
        chk("nochk_to_error", 32'(error), 0);
        chk("nochk_to_pending", 32'(pending), 1);
        out = 1'b0; step(4);
        chk("nochk_count", 32'(toggle_count), 1);
        chk("nochk_fall_pending", 32'(pending), 0);
        check_en = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/celem_monitor.md
CELEM_MONITOR -- requirements
Module: celem_monitor

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8: the maximum number of clk cycles that out may lag once it is armed to switch.
REQ-002 The block SHALL have parameter CNT_W, default 16: the width of the transition counter.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sampling clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in0  input  1  C-element input 0, asynchronous to clk.
REQ-007 in1  input  1  C-element input 1, asynchronous to clk.
REQ-008 out  input  1  C-element output under observation, asynchronous to clk.
REQ-009 check_en  input  1  enables error detection; tracking runs regardless.
REQ-010 clr  input  1  synchronous clear of error, err_code and toggle_count.
REQ-011 pending  output  1  out is armed to switch and has not yet switched.
REQ-012 error  output  1  sticky flag: a protocol violation occurred.
REQ-013 err_code  output  2  first violation: 0 none, 1 early transition, 2 timeout, 3 input retraction.
REQ-014 toggle_count  output  CNT_W  count of legal out transitions, saturating.

Function
REQ-015 in0, in1 and out SHALL each pass through a 2-flop synchronizer; all checks use the synchronized values s0, s1 and so.
REQ-016 The FSM SHALL have four states: LOW (so=0, not armed), ARM_R (s0&s1, so=0), HIGH (so=1, not armed) and ARM_F (~s0&~s1, so=1).
REQ-017 LOW SHALL go to ARM_R when s0&s1; HIGH SHALL go to ARM_F when ~s0&~s1.
REQ-018 ARM_R SHALL go to HIGH when so rises; ARM_F SHALL go to LOW when so falls; each such move SHALL increment toggle_count.
REQ-019 Where the arm condition and the out edge occur in the same sample, the transition SHALL be legal: the FSM goes directly to HIGH or LOW and the count increments.
REQ-020 An so rise in LOW without s0&s1, or an so fall in HIGH without ~s0&~s1, SHALL be an early transition (code 1); the FSM then follows so into HIGH or LOW and the count does not increment.
REQ-021 In ARM_R, loss of s0&s1 before so rises SHALL be a retraction (code 3) and return the FSM to LOW; in ARM_F, loss of ~s0&~s1 before so falls SHALL be code 3 and return the FSM to HIGH.
REQ-022 A wait counter SHALL clear on entry to ARM_R or ARM_F and increment each cycle spent there.
REQ-023 When the wait counter reaches TIMEOUT, the block SHALL record a timeout (code 2) once per arming and remain in the armed state.
REQ-024 pending SHALL be 1 exactly when the FSM is in ARM_R or ARM_F.
REQ-025 error and err_code SHALL be registered and update one cycle after the offending sample.
REQ-026 err_code SHALL latch only the first violation; later violations SHALL NOT overwrite it.
REQ-027 When a violation and clr occur in the same cycle, clr SHALL win and the violation SHALL be dropped.
REQ-028 With check_en=0, no violation SHALL be recorded, the wait counter SHALL hold at 0, and the FSM and toggle_count SHALL still track.
REQ-029 toggle_count SHALL saturate at 2^CNT_W-1.
REQ-030 Total detection latency from a pin change to a registered output SHALL be 3 clk cycles.

Reset
REQ-031 While rst_n=0, the synchronizers, FSM (LOW), wait counter, toggle_count, error and err_code SHALL all be 0, pending=0.
REQ-032 Reset asserted mid-arming SHALL abort the arming with no error; after release, the FSM SHALL re-derive its state from samples starting in LOW.
REQ-033 If so=1 after reset, the first sample SHALL move the FSM LOW->HIGH without error and without counting.

Structure
REQ-034 The state encoding and err_code constants SHALL live in the shared package celem_mon_pkg.
REQ-035 The synchronizer SHALL be a sub-module sync2, instantiated three times.
REQ-036 The RTL SHALL be synthesizable and contain no delays.

Verification
REQ-037 Scenario: phase-shifted in0/in1 (half-period 10 clk, shift 5); out follows as an ideal C-element 2 clk after the second input -> toggle_count=4 after 2 periods, error=0.
REQ-038 Scenario: in0=1, in1=0, out forced 1 -> error=1, err_code=1, toggle_count unchanged.
REQ-039 Scenario: in0=in1=1, out held 0 for 12 cycles with TIMEOUT=8 -> err_code=2 exactly once, pending=1 throughout.
REQ-040 Scenario: in0=in1=1, then in1=0 after 3 cycles with out=0 -> err_code=3, FSM back in LOW, pending=0.
REQ-041 Scenario: violation with clr pulsed in the same cycle -> error stays 0; a later timeout -> err_code=2.
REQ-042 Scenario: rst_n pulsed low while in ARM_R -> all outputs 0; with CNT_W=2 and 5 legal toggles -> toggle_count=3.
